byteswap_seq: RTL and testbench

Chunking job sequencer for the byteswap kernel. It accepts one ap_ctrl_hs job (`gmem_ptr`, `xfer_size`), splits it into chunks of at most `C_CHUNK_BYTES`, and drives the read master and write master start/offset/length controls chunk by chunk. It waits for both masters to report done before advancing, and raises ap_done once the whole job completes. It sits between the host control registers and the read-master → swapper → write-master datapath, replacing direct wiring of `ap_start_pulse` to the masters.

---
 rtl/byteswap_seq_pkg.sv | 28 ++
 rtl/byteswap_seq.sv | 194 +++++++++++++++++++
 tb/tb_byteswap_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/byteswap_seq_pkg.sv
// rtl/byteswap_seq_pkg.sv - shared state encoding and helper functions for the byteswap chunk sequencer
package byteswap_seq_pkg;

    // Sequencer states; IDLE must stay at encoding 0 so the reset value reads naturally.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;

    // Bytes to move in the next chunk: the remainder, capped at the chunk size.
    function automatic logic [63:0] chunk_len(input logic [63:0] remaining,
                                              input logic [63:0] max_bytes);
        return (remaining > max_bytes) ? max_bytes : remaining;
    endfunction

    // True when both the pointer and the size are multiples of the (power-of-two) alignment.
    function automatic logic is_aligned(input logic [63:0] ptr,
                                        input logic [63:0] size,
                                        input logic [63:0] align);
        logic [63:0] mask;
        mask = align - 64'd1;
        return ((ptr & mask) == 64'd0) && ((size & mask) == 64'd0);
    endfunction

endpackage

// File: rtl/byteswap_seq.sv
// rtl/byteswap_seq.sv - ap_ctrl_hs job sequencer splitting a transfer into chunks for the read/write masters (optional BYTESWAP_SEQ_PERF_EN adds perf counters)
module byteswap_seq
    import byteswap_seq_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_CHUNK_BYTES     = 65536,
    parameter int C_ALIGN_BYTES     = 64
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         ap_ready,
    input  logic [C_ADDR_WIDTH-1:0]      gmem_ptr,
    input  logic [C_XFER_SIZE_WIDTH-1:0] xfer_size,
    output logic                         rd_start,
    output logic [C_ADDR_WIDTH-1:0]      rd_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0] rd_length,
    input  logic                         rd_done,
    output logic                         wr_start,
    output logic [C_ADDR_WIDTH-1:0]      wr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0] wr_length,
    input  logic                         wr_done,
`ifdef BYTESWAP_SEQ_PERF_EN
    output logic [31:0]                  perf_cycles,
    output logic [15:0]                  perf_chunks,
`endif
    output logic                         err
);

    localparam int AW = C_ADDR_WIDTH;
    localparam int XW = C_XFER_SIZE_WIDTH;

    seq_state_t    state;
    logic          start_r;
    logic          start_pulse;
    logic          accept;
    logic [AW-1:0] cur_ptr;
    logic [XW-1:0] remaining;
    logic [XW-1:0] chunk;
    logic          rd_seen;
    logic          wr_seen;
    logic          both_done;
    logic          job_aligned;
    logic [XW-1:0] first_chunk;
    logic [XW-1:0] rem_next;
    logic [AW-1:0] ptr_next;
    logic [XW-1:0] next_chunk;

    // Rising edge of the level start; start_r resets low so a start held through reset still fires.
    assign start_pulse = ap_start & ~start_r;
    assign accept      = (state == ST_IDLE) && start_pulse;

    // A chunk completes once each master has reported done, in any order or together.
    assign both_done = (rd_seen | rd_done) & (wr_seen | wr_done);

    assign job_aligned = is_aligned(64'(gmem_ptr), 64'(xfer_size), 64'(C_ALIGN_BYTES));
    assign first_chunk = XW'(chunk_len(64'(xfer_size), 64'(C_CHUNK_BYTES)));
    assign rem_next    = remaining - chunk;
    assign ptr_next    = cur_ptr + AW'(chunk);
    assign next_chunk  = XW'(chunk_len(64'(rem_next), 64'(C_CHUNK_BYTES)));

    assign ap_idle  = (state == ST_IDLE);
    assign ap_done  = (state == ST_DONE);
    assign ap_ready = ap_done;
    assign rd_start = (state == ST_ISSUE);
    assign wr_start = (state == ST_ISSUE);

    // Register the host start level for edge detection.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            start_r <= 1'b0;
        end else begin
            start_r <= ap_start;
        end
    end

    // Job state machine.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        if (!job_aligned || (xfer_size == '0)) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE:   state <= ST_WAIT;
                ST_WAIT:    if (both_done) state <= ST_ADVANCE;
                ST_ADVANCE: state <= (rem_next == '0) ? ST_DONE : ST_ISSUE;
                ST_DONE:    state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Sticky misalignment flag, cleared by each accepted job.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= ~job_aligned;
        end
    end

    // Job progress: current address, bytes left and the size of the chunk in flight.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cur_ptr   <= '0;
            remaining <= '0;
            chunk     <= '0;
        end else if (accept) begin
            cur_ptr   <= gmem_ptr;
            remaining <= xfer_size;
            chunk     <= first_chunk;
        end else if (state == ST_ADVANCE) begin
            cur_ptr   <= ptr_next;
            remaining <= rem_next;
            chunk     <= next_chunk;
        end
    end

    // Master command registers, loaded on the way into ISSUE so they are valid with the start pulse
    // and held steady while the masters run.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_offset <= '0;
            wr_offset <= '0;
            rd_length <= '0;
            wr_length <= '0;
        end else if (accept && job_aligned && (xfer_size != '0)) begin
            rd_offset <= gmem_ptr;
            wr_offset <= gmem_ptr;
            rd_length <= first_chunk;
            wr_length <= first_chunk;
        end else if ((state == ST_ADVANCE) && (rem_next != '0)) begin
            rd_offset <= ptr_next;
            wr_offset <= ptr_next;
            rd_length <= next_chunk;
            wr_length <= next_chunk;
        end
    end

    // Remember which masters have finished the current chunk; only WAIT listens to done pulses.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_seen <= 1'b0;
            wr_seen <= 1'b0;
        end else if (state == ST_ISSUE) begin
            rd_seen <= 1'b0;
            wr_seen <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (rd_done) rd_seen <= 1'b1;
            if (wr_done) wr_seen <= 1'b1;
        end
    end

`ifdef BYTESWAP_SEQ_PERF_EN
    logic perf_active;

    // Saturating job counters: cycles from the first ISSUE through DONE, and chunks issued.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            perf_active <= 1'b0;
            perf_cycles <= '0;
            perf_chunks <= '0;
        end else if (accept) begin
            perf_active <= 1'b0;
            perf_cycles <= '0;
            perf_chunks <= '0;
        end else begin
            if (state == ST_ISSUE) begin
                perf_active <= 1'b1;
            end else if (state == ST_DONE) begin
                perf_active <= 1'b0;
            end
            if (((state == ST_ISSUE) || perf_active) && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if ((state == ST_ISSUE) && (perf_chunks != '1)) begin
                perf_chunks <= perf_chunks + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_byteswap_seq.sv
// tb/tb_byteswap_seq.sv - directed self-checking bench for byteswap_seq (BYTESWAP_SEQ_PERF_EN adds perf checks)
module tb_byteswap_seq;

    logic        clk;
    logic        rst_n;
    logic        ap_start;
    logic        ap_idle;
    logic        ap_done;
    logic        ap_ready;
    logic [63:0] gmem_ptr;
    logic [31:0] xfer_size;
    logic        rd_start;
    logic [63:0] rd_offset;
    logic [31:0] rd_length;
    logic        rd_done;
    logic        wr_start;
    logic [63:0] wr_offset;
    logic [31:0] wr_length;
    logic        wr_done;
    logic        err;
`ifdef BYTESWAP_SEQ_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_chunks;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    byteswap_seq #(
        .C_ADDR_WIDTH      (64),
        .C_XFER_SIZE_WIDTH (32),
        .C_CHUNK_BYTES     (256),
        .C_ALIGN_BYTES     (64)
    ) dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .ap_start  (ap_start),
        .ap_idle   (ap_idle),
        .ap_done   (ap_done),
        .ap_ready  (ap_ready),
        .gmem_ptr  (gmem_ptr),
        .xfer_size (xfer_size),
        .rd_start  (rd_start),
        .rd_offset (rd_offset),
        .rd_length (rd_length),
        .rd_done   (rd_done),
        .wr_start  (wr_start),
        .wr_offset (wr_offset),
        .wr_length (wr_length),
        .wr_done   (wr_done),
`ifdef BYTESWAP_SEQ_PERF_EN
        .perf_cycles (perf_cycles),
        .perf_chunks (perf_chunks),
`endif
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the cycle after the sampled pulse.
    task automatic start_job(input logic [63:0] ptr, input logic [31:0] size, input bit hold);
        gmem_ptr  = ptr;
        xfer_size = size;
        ap_start  = 1'b1;
        @(negedge clk);
        if (!hold) ap_start = 1'b0;
    endtask

    // Entered in ISSUE; both dones after lat WAIT cycles; returns in the next ISSUE or DONE.
    task automatic run_chunk(input string tag, input logic [63:0] off, input logic [31:0] len, input int lat);
        chk({tag, ".rd_start"},  rd_start,  1);
        chk({tag, ".wr_start"},  wr_start,  1);
        chk({tag, ".rd_offset"}, rd_offset, off);
        chk({tag, ".wr_offset"}, wr_offset, off);
        chk({tag, ".rd_length"}, rd_length, len);
        chk({tag, ".wr_length"}, wr_length, len);
        chk({tag, ".idle"},      ap_idle,   0);
        @(negedge clk);
        chk({tag, ".wait_start"},  rd_start,  0);
        chk({tag, ".wait_offset"}, wr_offset, off);
        chk({tag, ".wait_length"}, rd_length, len);
        repeat (lat) @(negedge clk);
        rd_done = 1'b1;
        wr_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        wr_done = 1'b0;
        chk({tag, ".adv_start"}, rd_start, 0);
        chk({tag, ".adv_done"},  ap_done,  0);
        @(negedge clk);
    endtask

    // Entered in DONE; returns in IDLE.
    task automatic check_done(input string tag, input logic exp_err);
        chk({tag, ".ap_done"},  ap_done,  1);
        chk({tag, ".ap_ready"}, ap_ready, 1);
        chk({tag, ".rd_start"}, rd_start, 0);
        chk({tag, ".wr_start"}, wr_start, 0);
        chk({tag, ".err"},      err,      exp_err);
        @(negedge clk);
        chk({tag, ".done_low"}, ap_done,  0);
        chk({tag, ".idle"},     ap_idle,  1);
    endtask

    initial begin
        rst_n     = 1'b0;
        ap_start  = 1'b0;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        gmem_ptr  = '0;
        xfer_size = '0;
        repeat (2) @(negedge clk);
        chk("rst.idle",      ap_idle,   1);
        chk("rst.done",      ap_done,   0);
        chk("rst.ready",     ap_ready,  0);
        chk("rst.rd_start",  rd_start,  0);
        chk("rst.wr_start",  wr_start,  0);
        chk("rst.rd_offset", rd_offset, 0);
        chk("rst.rd_length", rd_length, 0);
        chk("rst.err",       err,       0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three full chunks.
        start_job(64'h1000, 32'h300, 1'b0);
        run_chunk("mc0", 64'h1000, 256, 2);
        run_chunk("mc1", 64'h1100, 256, 0);
        run_chunk("mc2", 64'h1200, 256, 3);
        check_done("mc", 1'b0);

        // Partial last chunk.
        start_job(64'h2000, 32'h140, 1'b0);
        run_chunk("pc0", 64'h2000, 256, 1);
        run_chunk("pc1", 64'h2100, 64, 1);
        check_done("pc", 1'b0);

        // wr_done five cycles before rd_done, then a joint done.
        start_job(64'h3000, 32'h200, 1'b0);
        chk("ord.issue", rd_start, 1);
        @(negedge clk);
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ord.hold_wait", rd_start, 0);
            @(negedge clk);
        end
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        chk("ord.advance", rd_start, 0);
        @(negedge clk);
        run_chunk("ord1", 64'h3100, 256, 2);
        check_done("ord", 1'b0);

        // Stray rd_done while idle.
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        @(negedge clk);
        chk("stray.idle",     ap_idle,  1);
        chk("stray.rd_start", rd_start, 0);
        chk("stray.done",     ap_done,  0);

        // Zero-length job.
        start_job(64'h4000, 32'h0, 1'b0);
        check_done("zero", 1'b0);

        // Misaligned pointer.
        start_job(64'h1004, 32'h100, 1'b0);
        check_done("misal", 1'b1);
        chk("misal.err_sticky", err, 1);

        // Reset in the middle of WAIT.
        start_job(64'h6000, 32'h200, 1'b0);
        chk("rw.issue", rd_start, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rw.idle",      ap_idle,   1);
        chk("rw.rd_offset", rd_offset, 0);
        chk("rw.wr_length", wr_length, 0);
        chk("rw.err",       err,       0);
        chk("rw.done",      ap_done,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Job after reset with ap_start left high.
        start_job(64'h5000, 32'h100, 1'b1);
        run_chunk("post", 64'h5000, 256, 1);
        check_done("post", 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("held.idle",     ap_idle,  1);
            chk("held.rd_start", rd_start, 0);
            @(negedge clk);
        end
        ap_start = 1'b0;
        @(negedge clk);

`ifdef BYTESWAP_SEQ_PERF_EN
        // Single chunk: ISSUE at T, joint done at T+10.
        start_job(64'h7000, 32'h100, 1'b0);
        run_chunk("perf", 64'h7000, 256, 9);
        check_done("perf", 1'b0);
        chk("perf.cycles", perf_cycles, 13);
        chk("perf.chunks", perf_chunks, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
